safe_code_store: RTL and testbench
==================================

// Module: safe_code_store
// PURPOSE
// - Datapath partner of the safe-unlock control FSM. Consumes savePW/saveAT
//   and returns MATCH.
// - Stores the password and the attempt code from switch input CODE_IN.
// - Compares the attempt with the password.
// - Counts consecutive failed attempts. After MAX_FAILS failures it enters a
//   timed lockout, during which MATCH is forced low.
// PARAMETERS
// - CODE_W          8           width of CODE_IN and the stored codes
// - MAX_FAILS       3           consecutive failures that trigger lockout (>=1)
// - LOCKOUT_CYCLES  50_000_000  lockout duration in clk cycles (>=1)
// - MASTER_CODE     8'hA5       override code; used only with SAFE_MASTER_CODE_EN
// PORTS
// - clk         in   1                   system clock, rising edge
// - RESETN      in   1                   asynchronous active-low reset
// - CODE_IN     in   CODE_W              code from switches, synchronous to clk
// - savePW      in   1                   from FSM: load password (level, may span cycles)
// - saveAT      in   1                   from FSM: load attempt (level, may span cycles)
// - MATCH       out  1                   to FSM: attempt equals password (combinational)
// - LOCKOUT     out  1                   lockout timer active (registered)
// - PW_VALID    out  1                   a password has been stored since reset
// - FAIL_COUNT  out  $clog2(MAX_FAILS+1) consecutive failed attempts
// BEHAVIOUR
// - Reset (async, RESETN=0), state held while RESETN=0:
//   pw_q=0, at_q=0, PW_VALID=0, FAIL_COUNT=0, LOCKOUT=0, timer=0, saveAT_d=0.
// - Password load: each cycle with savePW=1, pw_q<=CODE_IN and PW_VALID<=1.
//   The value present in the last savePW cycle wins.
// - Attempt load: each cycle with saveAT=1 and savePW=0, at_q<=CODE_IN.
//   savePW has priority when both are high; saveAT is ignored that cycle.
// - Compare source: cmp = saveAT ? CODE_IN : at_q. This gives zero latency,
//   because the FSM samples MATCH in the same cycle it asserts saveAT.
// - Compare result: MATCH = PW_VALID & ~LOCKOUT & (cmp == pw_q).
// - Attempt end: detected on the cycle after the last saveAT cycle
//   (saveAT_d=1, saveAT=0). The result is judged using at_q == pw_q.
//   - Success, with no lockout: FAIL_COUNT<=0.
//   - Failure, with no lockout and PW_VALID=1:
//     - FAIL_COUNT<=FAIL_COUNT+1.
//     - If the new value equals MAX_FAILS: LOCKOUT<=1, timer<=LOCKOUT_CYCLES-1.
//   - Attempt ending during lockout: ignored; no count and no state change.
//   - Attempt with PW_VALID=0: ignored; FAIL_COUNT stays 0.
// - Lockout FSM has two states:
//   - IDLE: LOCKOUT=0.
//   - LOCK: LOCKOUT=1; timer decrements each cycle. When timer==0 and
//     decrement is due: go to IDLE, FAIL_COUNT<=0.
// - FAIL_COUNT saturates at MAX_FAILS and never wraps.
// - A new savePW (password change) clears FAIL_COUNT. It does not end an
//   active lockout.
// - Timer width is $clog2(LOCKOUT_CYCLES). LOCKOUT_CYCLES=1 gives exactly one
//   LOCKOUT cycle.
// - Reset mid-lockout or mid-attempt returns immediately to the reset values;
//   the stored password is lost.
// CONFIGURATION
// - SAFE_MASTER_CODE_EN defined:
//   - MATCH is also 1 when cmp==MASTER_CODE, regardless of PW_VALID and
//     LOCKOUT.
//   - A master-code attempt end is a success: it clears FAIL_COUNT, forces
//     the lockout FSM to IDLE, and sets timer<=0.
// - SAFE_MASTER_CODE_EN undefined:
//   - MASTER_CODE is unused; no master-compare logic is synthesized.
//   - Only the stored password can match.
// TESTING
// - 1. Reset, savePW=1 for 2 cycles with CODE_IN=8'h3C, then saveAT=1 with
//   CODE_IN=8'h3C -> MATCH=1 in the same cycle; PW_VALID=1; FAIL_COUNT=0.
// - 2. pw=8'h3C; three attempts of 8'h11 -> FAIL_COUNT=1,2,3; LOCKOUT=1 the
//   cycle after the third saveAT ends.
// - 3. During lockout, saveAT with 8'h3C -> MATCH=0; FAIL_COUNT stays 3.
//   With LOCKOUT_CYCLES=20: LOCKOUT=0 and FAIL_COUNT=0 exactly 20 cycles
//   after entry; 8'h3C then gives MATCH=1.
// - 4. Two fails, then a correct attempt -> FAIL_COUNT=0. A further fail
//   -> FAIL_COUNT=1 and no lockout.
// - 5. savePW and saveAT both high with CODE_IN=8'h55 -> pw_q=8'h55 and
//   at_q unchanged. Then RESETN=0 mid-lockout -> all outputs 0 immediately,
//   without waiting for a clk edge.
// - 6. SAFE_MASTER_CODE_EN defined, in lockout: saveAT with 8'hA5 -> MATCH=1
//   that cycle; after the attempt ends, LOCKOUT=0 and FAIL_COUNT=0.
//   Without the macro the same stimulus -> MATCH=0.

Source files
------------

// File: rtl/safe_code_store.sv
// Password/attempt store with consecutive-failure lockout for the safe-unlock FSM.
// Optional master override code enabled by defining SAFE_MASTER_CODE_EN.
module safe_code_store #(
  parameter int                CODE_W         = 8,
  parameter int                MAX_FAILS      = 3,
  parameter int                LOCKOUT_CYCLES = 50_000_000,
  parameter logic [CODE_W-1:0] MASTER_CODE    = 8'hA5
) (
  input  logic                             clk,
  input  logic                             RESETN,
  input  logic [CODE_W-1:0]                CODE_IN,
  input  logic                             savePW,
  input  logic                             saveAT,
  output logic                             MATCH,
  output logic                             LOCKOUT,
  output logic                             PW_VALID,
  output logic [$clog2(MAX_FAILS+1)-1:0]   FAIL_COUNT
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [FW-1:0] MAX_F      = FW'(MAX_FAILS);
  localparam logic [FW-1:0] FAIL_ONE   = FW'(1'b1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1'b1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } lock_state_t;

  lock_state_t       state_r, state_core_s, state_nx_s;
  logic [TW-1:0]     timer_r, timer_core_s, timer_nx_s;
  logic [FW-1:0]     fail_r, fail_core_s, fail_nx_s, fail_inc_s;
  logic [CODE_W-1:0] pw_r, at_r, cmp_s;
  logic              pw_valid_r, save_at_d_r;
  logic              attempt_end_s, master_hit_s, master_end_s, master_clr_s;

  // Compare source bypasses the attempt register so MATCH is valid while saveAT is high.
  assign cmp_s = saveAT ? CODE_IN : at_r;

  // An attempt closes on the first cycle after saveAT drops; a concurrent password load takes precedence.
  assign attempt_end_s = save_at_d_r & ~saveAT & ~savePW;
  assign fail_inc_s    = fail_r + FAIL_ONE;

`ifdef SAFE_MASTER_CODE_EN
  assign master_hit_s = (cmp_s == MASTER_CODE);
  assign master_end_s = (at_r == MASTER_CODE);
`else
  logic [CODE_W-1:0] unused_master_s;
  assign unused_master_s = MASTER_CODE;
  assign master_hit_s    = 1'b0;
  assign master_end_s    = 1'b0;
`endif

  assign master_clr_s = attempt_end_s & master_end_s;

  assign MATCH      = (pw_valid_r & (state_r == IDLE) & (cmp_s == pw_r)) | master_hit_s;
  assign LOCKOUT    = (state_r == LOCK);
  assign PW_VALID   = pw_valid_r;
  assign FAIL_COUNT = fail_r;

  // Code storage: password load wins over attempt load.
  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) begin
      pw_r        <= '0;
      at_r        <= '0;
      pw_valid_r  <= 1'b0;
      save_at_d_r <= 1'b0;
    end else begin
      save_at_d_r <= saveAT;
      if (savePW) begin
        pw_r       <= CODE_IN;
        pw_valid_r <= 1'b1;
      end else if (saveAT) begin
        at_r <= CODE_IN;
      end
    end
  end

  // Lockout FSM and failure counter state.
  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) begin
      state_r <= IDLE;
      timer_r <= '0;
      fail_r  <= '0;
    end else begin
      state_r <= state_nx_s;
      timer_r <= timer_nx_s;
      fail_r  <= fail_nx_s;
    end
  end

  // Attempt judgement and lockout countdown.
  always_comb begin
    state_core_s = state_r;
    timer_core_s = timer_r;
    fail_core_s  = fail_r;
    case (state_r)
      IDLE: begin
        if (attempt_end_s && pw_valid_r) begin
          if (at_r == pw_r) begin
            fail_core_s = '0;
          end else if (fail_r < MAX_F) begin
            fail_core_s = fail_inc_s;
            if (fail_inc_s == MAX_F) begin
              state_core_s = LOCK;
              timer_core_s = TIMER_LOAD;
            end else begin
              state_core_s = IDLE;
            end
          end else begin
            fail_core_s = fail_r;
          end
        end else begin
          fail_core_s = fail_r;
        end
      end
      LOCK: begin
        if (timer_r == '0) begin
          state_core_s = IDLE;
          fail_core_s  = '0;
        end else begin
          timer_core_s = timer_r - TIMER_ONE;
        end
      end
      default: begin
        state_core_s = IDLE;
        timer_core_s = '0;
        fail_core_s  = '0;
      end
    endcase
  end

  // Master override and password change act on top of the normal judgement.
  always_comb begin
    state_nx_s = state_core_s;
    timer_nx_s = timer_core_s;
    fail_nx_s  = fail_core_s;
    if (master_clr_s) begin
      state_nx_s = IDLE;
      timer_nx_s = '0;
      fail_nx_s  = '0;
    end else if (savePW) begin
      fail_nx_s = '0;
    end else begin
      fail_nx_s = fail_core_s;
    end
  end

endmodule

// File: tb/tb_safe_code_store.sv
// Randomized + directed bench for safe_code_store against a cycle-level behavioural model.
// The master-code expectations follow SAFE_MASTER_CODE_EN when it is defined for the build.
module tb_safe_code_store;

  localparam int          MAXF = 3;
  localparam int          LC   = 20;
  localparam logic [7:0]  MC   = 8'hA5;

  logic       clk = 1'b0;
  logic       RESETN = 1'b0;
  logic [7:0] CODE_IN = 8'h00;
  logic       savePW = 1'b0;
  logic       saveAT = 1'b0;
  logic       MATCH, LOCKOUT, PW_VALID;
  logic [1:0] FAIL_COUNT;

  int n_vec = 0;
  int n_err = 0;

  safe_code_store #(
    .CODE_W(8), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LC), .MASTER_CODE(MC)
  ) dut (
    .clk(clk), .RESETN(RESETN), .CODE_IN(CODE_IN), .savePW(savePW), .saveAT(saveAT),
    .MATCH(MATCH), .LOCKOUT(LOCKOUT), .PW_VALID(PW_VALID), .FAIL_COUNT(FAIL_COUNT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: lock_left counts remaining lockout cycles (0 = not locked).
  logic [7:0] m_pw = 8'h00, m_at = 8'h00;
  bit         m_valid = 0, m_prev_at = 0;
  int         m_fails = 0, m_lock = 0;

  always @(negedge clk) begin
    logic [7:0] cmp;
    bit         exp_match, aend;
    int         n_fails, n_lock;
    if (!RESETN) begin
      m_pw = 8'h00; m_at = 8'h00; m_valid = 0; m_prev_at = 0; m_fails = 0; m_lock = 0;
    end
    cmp = saveAT ? CODE_IN : m_at;
    exp_match = m_valid && (m_lock == 0) && (cmp == m_pw);
`ifdef SAFE_MASTER_CODE_EN
    if (cmp == MC) exp_match = 1;
`endif
    chk("match", MATCH, exp_match);
    chk("lockout", LOCKOUT, (m_lock > 0));
    chk("pw_valid", PW_VALID, m_valid);
    chk("fail_count", FAIL_COUNT, m_fails);
    if (RESETN) begin
      aend = m_prev_at && !saveAT && !savePW;
      n_fails = m_fails;
      n_lock = m_lock;
      if (m_lock > 0) begin
        n_lock = m_lock - 1;
        if (n_lock == 0) n_fails = 0;
      end else if (aend && m_valid) begin
        if (m_at == m_pw) n_fails = 0;
        else if (m_fails < MAXF) begin
          n_fails = m_fails + 1;
          if (n_fails == MAXF) n_lock = LC;
        end
      end
`ifdef SAFE_MASTER_CODE_EN
      if (aend && m_at == MC) begin n_fails = 0; n_lock = 0; end
`endif
      if (savePW) n_fails = 0;
      if (savePW) begin m_pw = CODE_IN; m_valid = 1; end
      else if (saveAT) m_at = CODE_IN;
      m_prev_at = saveAT;
      m_fails = n_fails;
      m_lock = n_lock;
    end
  end

  task automatic step(input logic pw, input logic at, input logic [7:0] code);
    @(posedge clk); #1;
    savePW = pw; saveAT = at; CODE_IN = code;
  endtask

  task automatic attempt(input logic [7:0] code);
    step(1'b0, 1'b1, code);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic probe();
    @(negedge clk); #1;
  endtask

  initial begin
    bit master_on;
`ifdef SAFE_MASTER_CODE_EN
    master_on = 1;
`else
    master_on = 0;
`endif
    repeat (3) @(posedge clk);
    probe();
    chk("reset_lockout", LOCKOUT, 0);
    chk("reset_pw_valid", PW_VALID, 0);
    chk("reset_fail", FAIL_COUNT, 0);
    @(posedge clk); #1 RESETN = 1'b1;

    // 1: password load, zero-latency match
    step(1'b1, 1'b0, 8'h3C);
    step(1'b1, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h3C);
    probe();
    chk("t1_match", MATCH, 1);
    chk("t1_pw_valid", PW_VALID, 1);
    chk("t1_fail", FAIL_COUNT, 0);
    step(1'b0, 1'b0, 8'h00);

    // 2: three failures into lockout
    for (int k = 1; k <= 3; k++) begin
      attempt(8'h11);
      probe();
      chk("t2_fail", FAIL_COUNT, k);
      chk("t2_lockout", LOCKOUT, (k == 3));
    end

    // 3: lockout masks correct code, expires after LC cycles
    step(1'b0, 1'b1, 8'h3C);
    probe();
    chk("t3_match_locked", MATCH, 0);
    step(1'b0, 1'b0, 8'h00);
    repeat (17) step(1'b0, 1'b0, 8'h00);
    probe();
    chk("t3_lock_last", LOCKOUT, 1);
    chk("t3_fail_held", FAIL_COUNT, 3);
    step(1'b0, 1'b0, 8'h00);
    probe();
    chk("t3_lock_end", LOCKOUT, 0);
    chk("t3_fail_clr", FAIL_COUNT, 0);
    step(1'b0, 1'b1, 8'h3C);
    probe();
    chk("t3_match_after", MATCH, 1);
    step(1'b0, 1'b0, 8'h00);

    // 4: success clears the count
    attempt(8'h11);
    attempt(8'h11);
    probe();
    chk("t4_two", FAIL_COUNT, 2);
    attempt(8'h3C);
    probe();
    chk("t4_clr", FAIL_COUNT, 0);
    attempt(8'h11);
    probe();
    chk("t4_one", FAIL_COUNT, 1);
    chk("t4_nolock", LOCKOUT, 0);

    // 5: savePW priority, then async reset mid-lockout
    step(1'b1, 1'b1, 8'h55);
    step(1'b0, 1'b0, 8'h55);
    probe();
    chk("t5_at_kept", MATCH, 0);
    step(1'b0, 1'b1, 8'h55);
    probe();
    chk("t5_pw_new", MATCH, 1);
    step(1'b0, 1'b0, 8'h00);
    repeat (3) attempt(8'h11);
    probe();
    chk("t5_locked", LOCKOUT, 1);
    @(posedge clk); #2 RESETN = 1'b0;
    #1;
    chk("t5_rst_lock", LOCKOUT, 0);
    chk("t5_rst_valid", PW_VALID, 0);
    chk("t5_rst_fail", FAIL_COUNT, 0);
    chk("t5_rst_match", MATCH, 0);
    savePW = 1'b0; saveAT = 1'b0; CODE_IN = 8'h00;
    @(posedge clk); #1 RESETN = 1'b1;

    // 6: master code in lockout
    step(1'b1, 1'b0, 8'h3C);
    step(1'b0, 1'b0, 8'h00);
    repeat (3) attempt(8'h11);
    step(1'b0, 1'b1, MC);
    probe();
    chk("t6_match", MATCH, master_on);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    probe();
    chk("t6_lock", LOCKOUT, !master_on);
    chk("t6_fail", FAIL_COUNT, master_on ? 0 : 3);

    // Random phase; codes drawn from a small set so matches and master hits occur.
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] c;
      @(posedge clk); #1;
      RESETN  = ($urandom_range(0, 599) != 0);
      savePW  = ($urandom_range(0, 19) == 0);
      saveAT  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: c = 8'h3C;
        1: c = MC;
        default: c = 8'h38 | 8'($urandom_range(0, 7));
      endcase
      CODE_IN = c;
    end
    @(posedge clk); #1;
    RESETN = 1'b1; savePW = 1'b0; saveAT = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
